// File: rtl/fp16_add_arbiter.sv
// Round-robin front end for one shared, fixed-latency FP16 adder. Each requester has a
// one-op slot; results are matched by tag against a latency pipe and parked in a response buffer.
//
// state      | meaning
// S_IDLE     | no op outstanding, eligible for grant
// S_INFLIGHT | op issued to the adder, waiting for its tagged result
// S_HOLD     | result buffered in rsp_data, waiting for rsp_ready
module fp16_add_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [16*NREQ-1:0]   rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 add_valid,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic [TAGW-1:0]      add_tag,
  input  logic                 add_res_valid,
  input  logic [15:0]          add_res,
  input  logic [TAGW-1:0]      add_res_tag,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE, S_INFLIGHT, S_HOLD} slot_t;

  slot_t           slot_q [NREQ];
  slot_t           slot_d [NREQ];
  logic [NREQ-1:0] eligible;
  logic [TAGW-1:0] rr_ptr;
  logic            grant_any;
  logic [TAGW-1:0] grant_idx;
  logic [LAT-1:0]  pipe_valid;
  logic [TAGW-1:0] pipe_tag [LAT];
  logic            exp_valid;
  logic [TAGW-1:0] exp_tag;
  logic            tag_inflight;
  logic            capture;
  logic            proto_err;
  logic [NREQ-1:0] slot_busy;

  // Rotating priority scan starting at rr_ptr; first eligible requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (slot_q[i] == S_IDLE);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && eligible[(int'(rr_ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = TAGW'((int'(rr_ptr) + k) % NREQ);
        req_ready[(int'(rr_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_tag   <= '0;
      rr_ptr    <= '0;
    end else begin
      add_valid <= grant_any;
      if (grant_any) begin
        add_a   <= req_a[16*int'(grant_idx) +: 16];
        add_b   <= req_b[16*int'(grant_idx) +: 16];
        add_tag <= grant_idx;
        rr_ptr  <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Expected-tag pipe mirrors the adder latency so each result can be checked on arrival.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      for (int k = 0; k < LAT; k++) pipe_tag[k] <= '0;
    end else begin
      pipe_valid[0] <= add_valid;
      pipe_tag[0]   <= add_tag;
      for (int k = 1; k < LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_tag[k]   <= pipe_tag[k-1];
      end
    end
  end

  assign exp_valid = pipe_valid[LAT-1];
  assign exp_tag   = pipe_tag[LAT-1];

  always_comb begin
    tag_inflight = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (add_res_tag == TAGW'(i) && slot_q[i] == S_INFLIGHT) tag_inflight = 1'b1;
    end
    capture   = add_res_valid && exp_valid && (add_res_tag == exp_tag) && tag_inflight;
    proto_err = (add_res_valid && !capture) || (exp_valid && !add_res_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (proto_err) err <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (capture && add_res_tag == TAGW'(i)) rsp_data[16*i +: 16] <= add_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) slot_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < NREQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        S_IDLE:     if (grant_any && grant_idx == TAGW'(i)) slot_d[i] = S_INFLIGHT;
        S_INFLIGHT: if (capture && add_res_tag == TAGW'(i)) slot_d[i] = S_HOLD;
        S_HOLD:     if (rsp_ready[i]) slot_d[i] = S_IDLE;
        default:    slot_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (slot_q[i] == S_HOLD);
      slot_busy[i] = (slot_q[i] != S_IDLE);
    end
    busy = (|slot_busy) || (|pipe_valid);
  end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: a latency-accurate adder model plus issue/response scoreboards
// checked by a negedge monitor, driven by directed vectors with hand-computed FP16 sums.
module tb_fp16_add_arbiter;
  localparam int NREQ = 4;
  localparam int TAGW = 2;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [16*NREQ-1:0]  req_a = '0;
  logic [16*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [16*NREQ-1:0]  rsp_data;
  logic [NREQ-1:0]     rsp_ready = '1;
  logic                add_valid;
  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic [TAGW-1:0]     add_tag;
  logic                add_res_valid = 1'b0;
  logic [15:0]         add_res = '0;
  logic [TAGW-1:0]     add_res_tag = '0;
  logic                busy;
  logic                err;

  fp16_add_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_tag(add_tag),
    .add_res_valid(add_res_valid), .add_res(add_res), .add_res_tag(add_res_tag),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [TAGW-1:0] tag; logic [15:0] a; logic [15:0] b;} iss_t;
  typedef struct packed {logic v; logic [TAGW-1:0] tag; logic [15:0] res;} mdl_t;

  iss_t        iss_q[$];
  logic [15:0] rsp_q[NREQ][$];
  iss_t        mon_e;
  mdl_t        dl[LAT];
  mdl_t        mo;
  logic        corrupt_en = 1'b0;
  logic        drop_en = 1'b0;
  logic        stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Hand-computed IEEE half-precision sums for the vectors used below.
  function automatic logic [15:0] fp_sum(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h3C00, 16'h4000}: return 16'h4200;
      {16'h3C00, 16'h3C00}: return 16'h4000;
      {16'h4000, 16'h4000}: return 16'h4400;
      {16'h4200, 16'h3C00}: return 16'h4400;
      {16'h4400, 16'h4400}: return 16'h4800;
      {16'h3800, 16'h3800}: return 16'h3C00;
      {16'h0002, 16'h8001}: return 16'h0001;
      default:              return 16'h7E00;
    endcase
  endfunction

  // Adder model: result for an op seen during cycle c is driven during cycle c+LAT.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) dl[k] = '0;
      add_res_valid = 1'b0;
      add_res       = '0;
      add_res_tag   = '0;
    end else begin
      mo = dl[LAT-1];
      for (int k = LAT - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = {add_valid, add_tag, fp_sum(add_a, add_b)};
      if (stray_en) begin
        add_res_valid = 1'b1;
        add_res_tag   = 2'd2;
        add_res       = 16'h1234;
      end else begin
        add_res_valid = mo.v && !drop_en;
        add_res_tag   = corrupt_en ? 2'd3 : mo.tag;
        add_res       = mo.res;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (add_valid) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected actual=tag%0d required=none", add_tag);
        end else begin
          mon_e = iss_q.pop_front();
          chk("issue_tag", 32'(add_tag), 32'(mon_e.tag));
          chk("issue_a", 32'(add_a), 32'(mon_e.a));
          chk("issue_b", 32'(add_b), 32'(mon_e.b));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (rsp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=req%0d required=none", i);
          end else begin
            chk("rsp_data", 32'(rsp_data[16*i +: 16]), 32'(rsp_q[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    corrupt_en = 1'b0;
    drop_en = 1'b0;
    stray_en = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_issue(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (add_valid && add_tag == TAGW'(i)) seen = 1'b1;
    end
    req_valid[i] = 1'b0;
    if (!seen) fail_to("issue_wait");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) fail_to("idle_wait");
  endtask

  task automatic wait_rsp(input int i);
    bit done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (rsp_valid[i]) done = 1'b1;
    end
    if (!done) fail_to("rsp_wait");
  endtask

  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    iss_q.push_back({TAGW'(i), a, b});
    rsp_q[i].push_back(exp);
    @(posedge clk); #1;
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    wait_issue(i);
    wait_idle();
  endtask

  task automatic test_single();
    iss_q.push_back({2'd0, 16'h3C00, 16'h4000});
    rsp_q[0].push_back(16'h4200);
    @(posedge clk); #1;
    set_ops(0, 16'h3C00, 16'h4000);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_add_valid", 32'(add_valid), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    repeat (LAT) @(negedge clk);
    chk("single_rsp_early", 32'(rsp_valid[0]), 32'h0);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    @(negedge clk);
    chk("single_rsp_done", 32'(rsp_valid[0]), 32'h0);
    chk("single_busy_end", 32'(busy), 32'h0);
  endtask

  task automatic test_fair();
    logic [15:0] fa[NREQ];
    logic [15:0] fb[NREQ];
    logic [15:0] fr[NREQ];
    int cnt[NREQ];
    int last[NREQ];
    int total = 0;
    int cyc = 0;
    int t;
    fa = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    fb = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4400};
    fr = '{16'h4000, 16'h4400, 16'h4400, 16'h4800};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        iss_q.push_back({TAGW'(i), fa[i], fb[i]});
        rsp_q[i].push_back(fr[i]);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, fa[i], fb[i]);
      cnt[i] = 0;
      last[i] = 0;
    end
    @(posedge clk); #1;
    req_valid = '1;
    for (int n = 0; n < 60 && total < 2 * NREQ; n++) begin
      @(posedge clk); #1;
      cyc++;
      if (add_valid) begin
        t = int'(add_tag);
        cnt[t]++;
        if (cnt[t] == 2) begin
          chk("fair_regrant_gap", 32'(cyc - last[t]), 32'(LAT + 3));
          req_valid[t] = 1'b0;
        end
        last[t] = cyc;
        total++;
      end
    end
    req_valid = '0;
    if (total < 2 * NREQ) fail_to("fair_issues");
    wait_idle();
  endtask

  task automatic test_backpressure();
    rsp_ready[1] = 1'b0;
    iss_q.push_back({2'd1, 16'h4000, 16'h4000});
    rsp_q[1].push_back(16'h4400);
    iss_q.push_back({2'd1, 16'h3800, 16'h3800});
    rsp_q[1].push_back(16'h3C00);
    @(posedge clk); #1;
    set_ops(1, 16'h4000, 16'h4000);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    set_ops(1, 16'h3800, 16'h3800);
    wait_rsp(1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid[1]), 32'h1);
      chk("bp_rsp_data", 32'(rsp_data[31:16]), 32'h4400);
      chk("bp_req_ready", 32'(req_ready[1]), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_grant", 32'(req_ready[1]), 32'h0);
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready[1]), 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();
  endtask

  task automatic test_protocol();
    chk("proto_err_before", 32'(err), 32'h0);
    iss_q.push_back({2'd1, 16'h3C00, 16'h3C00});
    corrupt_en = 1'b1;
    @(posedge clk); #1;
    set_ops(1, 16'h3C00, 16'h3C00);
    req_valid[1] = 1'b1;
    wait_issue(1);
    repeat (LAT + 2) @(negedge clk);
    chk("proto_err_set", 32'(err), 32'h1);
    chk("proto_rsp3", 32'(rsp_valid[3]), 32'h0);
    chk("proto_rsp1", 32'(rsp_valid[1]), 32'h0);
    chk("proto_busy", 32'(busy), 32'h1);
    corrupt_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("proto_err_sticky", 32'(err), 32'h1);
  endtask

  task automatic test_reset_flight();
    int total = 0;
    iss_q.push_back({2'd2, 16'h4000, 16'h4000});
    iss_q.push_back({2'd3, 16'h4400, 16'h4400});
    iss_q.push_back({2'd0, 16'h3C00, 16'h4000});
    @(posedge clk); #1;
    set_ops(2, 16'h4000, 16'h4000);
    set_ops(3, 16'h4400, 16'h4400);
    set_ops(0, 16'h3C00, 16'h4000);
    req_valid = 4'b1101;
    for (int n = 0; n < 20 && total < 3; n++) begin
      @(posedge clk); #1;
      if (add_valid) begin
        req_valid[add_tag] = 1'b0;
        total++;
      end
    end
    if (total < 3) fail_to("flight_issues");
    @(negedge clk);
    chk("flight_busy", 32'(busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_add_valid", 32'(add_valid), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_add_b", 32'(add_b), 32'h0);
    chk("rst_add_tag", 32'(add_tag), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data[31:0], 32'h0);
    chk("rst_rsp_data_hi", rsp_data[63:32], 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    stray_en = 1'b1;
    @(posedge clk); #1;
    stray_en = 1'b0;
    @(negedge clk);
    chk("stray_err", 32'(err), 32'h1);
    do_reset();
    @(negedge clk);
    chk("rst2_err", 32'(err), 32'h0);
    run_op(3, 16'h3800, 16'h3800, 16'h3C00);
    chk("rst2_err_after_op", 32'(err), 32'h0);
  endtask

  task automatic test_drop();
    iss_q.push_back({2'd0, 16'h3C00, 16'h3C00});
    drop_en = 1'b1;
    @(posedge clk); #1;
    set_ops(0, 16'h3C00, 16'h3C00);
    req_valid[0] = 1'b1;
    wait_issue(0);
    repeat (LAT + 2) @(negedge clk);
    chk("drop_err", 32'(err), 32'h1);
    chk("drop_rsp0", 32'(rsp_valid[0]), 32'h0);
    chk("drop_busy", 32'(busy), 32'h1);
    drop_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_add_valid", 32'(add_valid), 32'h0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("init_req_ready", 32'(req_ready), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    test_single();
    do_reset();
    test_fair();
    test_backpressure();
    run_op(2, 16'h0002, 16'h8001, 16'h0001);
    test_protocol();
    test_reset_flight();
    test_drop();
    repeat (2) @(negedge clk);
    chk("end_iss_q_empty", 32'(iss_q.size()), 32'h0);
    for (int i = 0; i < NREQ; i++) chk("end_rsp_q_empty", 32'(rsp_q[i].size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
